result_drain: RTL and testbench
===============================

Name: result_drain

Overview:
- Consumer end of the systolic array result interface.
- Accepts one full output row per cycle from the array top: packed vector of ARRAY_W elements plus tile-row and tile-col tags.
- Buffers rows in a small FIFO and serializes them one element per beat onto a valid/ready stream for host readback or a writer.
- Sits directly after `top`'s `out` bus; the array never stalls, so the block flags overflow instead of back-pressuring.

Parameters:
- DATA_W, 32, element width; equals `OUTPUT_BUF_DATASIZE.
- ARRAY_W, 8, elements per row; equals `ARRAYWIDTH.
- DEPTH, 4, row FIFO depth; power of two, ≥2.
- TR_W, 3, tile row index width.
- TC_W, 5, tile col index width.

Ports:
- clk, input, 1, single clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- row_valid, input, 1, row present this cycle.
- row_data, input, DATA_W*ARRAY_W, element k at bits [k*DATA_W +: DATA_W].
- row_tile_row, input, TR_W, tile row tag.
- row_tile_col, input, TC_W, tile col tag.
- row_last, input, 1, final row of the whole job.
- m_valid, output, 1, element beat valid.
- m_ready, input, 1, downstream accept.
- m_data, output, DATA_W, element value.
- m_tile_row, output, TR_W, tag of the current row.
- m_tile_col, output, TC_W, tag of the current row.
- m_elem_idx, output, $clog2(ARRAY_W), element index within the row.
- m_last, output, 1, last element of a row_last row.
- done, output, 1, one-cycle pulse.
- overflow, output, 1, sticky drop flag.
- fifo_level, output, $clog2(DEPTH)+1, rows buffered.

Behaviour:
- Reset (rst=1 at an edge): all outputs and state go to 0 and the FIFO empties. A reset mid-row or mid-beat discards all data. m_valid is 0 in the cycle after the reset edge.
- Push: a row is written when row_valid=1 and (level<DEPTH or a pop happens the same edge). Data and tags are stored together with row_last.
- Full: if row_valid=1, level=DEPTH and there is no simultaneous pop, the row is dropped and overflow is set to 1. overflow clears only on rst.
- Serializer FSM:
  - IDLE: if level>0, pop the head into the shift register, set elem_idx=0, go to SEND. m_valid=1 from the next cycle.
  - SEND: m_valid=1, m_data=element elem_idx, tags held. On m_valid&m_ready:
    - if elem_idx<ARRAY_W-1, increment elem_idx.
    - else, if level>0, pop the next row and stay in SEND (back-to-back, no bubble); otherwise go to IDLE with m_valid=0 next cycle.
- Latency: a row sampled at edge t into an empty FIFO gives m_valid=1 after edge t+1, i.e. 2 cycles. A full row drains in ARRAY_W accepted beats.
- Hold rule: while m_valid=1 and m_ready=0, m_data, tags, m_elem_idx and m_last are stable.
- m_last is 1 only on beat ARRAY_W-1 of a row pushed with row_last=1.
- done pulses exactly one cycle, the cycle after the m_last handshake.
- Simultaneous push and pop: net level is unchanged, even at level=DEPTH.
- fifo_level counts stored rows only; it excludes the row held in the serializer.

Optional Feature:
- RESULT_DRAIN_CHECKSUM_EN defined:
  - Adds output port checksum [DATA_W-1:0].
  - checksum is a wrap-around sum of every handshaken m_data.
  - It updates the cycle after each beat, clears on rst, and clears on the cycle after done pulses.
  - The final-job value is held on the done cycle.
- Not defined: the port and adder are absent; all other behaviour is identical.

Decomposition:
- config.v holds OUTPUT_BUF_DATASIZE, ARRAYWIDTH and the tile-index widths; parameter defaults derive from it.
- FSM state encodings (IDLE=0, SEND=1) are local parameters.
- One sub-module, row_fifo:
  - Parameterized width and depth.
  - Synchronous push/pop, full/empty and level outputs.
  - Same-edge push-when-full-with-pop is allowed.
- result_drain holds the serializer FSM, the tag registers and the optional checksum.

Test Plan:
- Single row, data 0..7, tags (2,5), m_ready=1 → m_valid rises 2 cycles after row_valid; beats 0..7 are consecutive with tags 2/5; m_elem_idx runs 0..7; m_last=0.
- Four back-to-back rows with m_ready=1 → 32 consecutive beats with no bubble; fifo_level peaks at 3.
- m_ready toggles 1/0 every cycle during a row → every element appears exactly once; outputs are stable during stalls.
- m_ready=0, push 5 rows with DEPTH=4 → the 1st row is in the serializer, 4 are buffered, no drop, overflow=0. A 6th row sets overflow=1 and is never emitted. Pushing a row at level=4 on the same cycle as a pop is accepted.
- Final row with row_last=1 → m_last=1 on its beat 7; done pulses once, the next cycle. With RESULT_DRAIN_CHECKSUM_EN, checksum equals the sum of all emitted elements (rows 0..7 and 8..15 give 120).
- Assert rst mid-row at beat 3 → next cycle m_valid=0 and fifo_level=0; a new row afterwards starts at m_elem_idx=0.

Source files
------------

// File: rtl/result_drain_pkg.sv
// result_drain shared sizing constants and helpers.
// Defaults mirror the array output buffer and tile index configuration.
package result_drain_pkg;

  // Array output configuration the drain is sized against.
  localparam int OUTPUT_BUF_DATASIZE = 32;
  localparam int ARRAYWIDTH          = 8;
  localparam int TILE_ROW_W          = 3;
  localparam int TILE_COL_W          = 5;
  localparam int ROW_FIFO_DEPTH      = 4;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Width of one stored row: data, tags and the job-last marker.
  function automatic int entry_w(
    input int data_w,
    input int array_w,
    input int tr_w,
    input int tc_w
  );
    return data_w * array_w + tr_w + tc_w + 1;
  endfunction

endpackage

// File: rtl/row_fifo.sv
// row_fifo: synchronous row buffer with level count.
// A push while full is accepted when a pop happens on the same edge.
module row_fifo
  import result_drain_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic                      full,
  output logic                      empty,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == LW'(DEPTH));
  assign level   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy tracking; simultaneous push/pop nets to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + LW'(do_push) - LW'(do_pop);
    end
  end

  // Storage array; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/result_drain.sv
// result_drain: buffers array output rows, serializes one element per beat.
// Optional RESULT_DRAIN_CHECKSUM_EN adds a running sum of emitted beats.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int DATA_W  = OUTPUT_BUF_DATASIZE,
  parameter int ARRAY_W = ARRAYWIDTH,
  parameter int DEPTH   = ROW_FIFO_DEPTH,
  parameter int TR_W    = TILE_ROW_W,
  parameter int TC_W    = TILE_COL_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        row_valid,
  input  logic [DATA_W*ARRAY_W-1:0]   row_data,
  input  logic [TR_W-1:0]             row_tile_row,
  input  logic [TC_W-1:0]             row_tile_col,
  input  logic                        row_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_W-1:0]           m_data,
  output logic [TR_W-1:0]             m_tile_row,
  output logic [TC_W-1:0]             m_tile_col,
  output logic [$clog2(ARRAY_W)-1:0]  m_elem_idx,
  output logic                        m_last,
  output logic                        done,
`ifdef RESULT_DRAIN_CHECKSUM_EN
  output logic [DATA_W-1:0]           checksum,
`endif
  output logic                        overflow,
  output logic [$clog2(DEPTH):0]      fifo_level
);

  localparam int RW = DATA_W * ARRAY_W;
  localparam int IW = $clog2(ARRAY_W);
  localparam int EW = entry_w(DATA_W, ARRAY_W, TR_W, TC_W);
  localparam int LW = level_w(DEPTH);

  localparam logic IDLE = 1'b0;
  localparam logic SEND = 1'b1;

  logic          state;
  logic          state_nxt;

  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;
  logic [RW-1:0] head_data;
  logic [TR_W-1:0] head_tr;
  logic [TC_W-1:0] head_tc;
  logic          head_last;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] level;

  logic [RW-1:0] sreg;
  logic [IW-1:0] elem_idx;
  logic [TR_W-1:0] cur_tr;
  logic [TC_W-1:0] cur_tc;
  logic          cur_last;
  logic          done_q;
  logic          ovf_q;

  logic          beat;
  logic          at_end;
  logic          load;
  logic          drop;

  assign wr_entry = {row_last, row_tile_col, row_tile_row, row_data};
  assign {head_last, head_tc, head_tr, head_data} = head;

  row_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (row_valid),
    .pop   (load),
    .wdata (wr_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign at_end = (elem_idx == IW'(ARRAY_W - 1));
  assign beat   = m_valid && m_ready;
  assign load   = !fifo_empty &&
                  ((state == IDLE) || (beat && at_end));
  assign drop   = row_valid && fifo_full && !load;

  // Serializer state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: leave IDLE on any buffered row, return when drained.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (!fifo_empty) state_nxt = SEND;
      SEND: if (beat && at_end && fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stream outputs decoded from state and the held row.
  always_comb begin
    m_valid = (state == SEND);
    m_last  = (state == SEND) && cur_last && at_end;
  end

  assign m_data     = sreg[DATA_W-1:0];
  assign m_tile_row = cur_tr;
  assign m_tile_col = cur_tc;
  assign m_elem_idx = elem_idx;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign fifo_level = level;

  // Row shift register: load head on pop, shift one element per beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg     <= '0;
      elem_idx <= '0;
      cur_tr   <= '0;
      cur_tc   <= '0;
      cur_last <= 1'b0;
    end else if (load) begin
      sreg     <= head_data;
      elem_idx <= '0;
      cur_tr   <= head_tr;
      cur_tc   <= head_tc;
      cur_last <= head_last;
    end else if (beat && !at_end) begin
      sreg     <= sreg >> DATA_W;
      elem_idx <= elem_idx + 1'b1;
    end
  end

  // Job completion pulse and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= beat && m_last;
      if (drop) ovf_q <= 1'b1;
    end
  end

`ifdef RESULT_DRAIN_CHECKSUM_EN
  logic [DATA_W-1:0] csum;

  assign checksum = csum;

  // Running sum; restarts after the done cycle shows the job total.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= '0;
    end else if (done_q) begin
      csum <= beat ? m_data : '0;
    end else if (beat) begin
      csum <= csum + m_data;
    end
  end
`endif

endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: scoreboard bench for result_drain.
// Expected beats are queued at row push and compared on handshake.
module tb_result_drain;

  localparam int DW = 32;
  localparam int AW = 8;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  tr;
    logic [4:0]  tc;
    logic [2:0]  idx;
    logic        last;
  } beat_t;

  logic           clk = 0;
  logic           rst = 1;
  logic           row_valid = 0;
  logic [255:0]   row_data = '0;
  logic [2:0]     row_tile_row = '0;
  logic [4:0]     row_tile_col = '0;
  logic           row_last = 0;
  logic           m_valid;
  logic           m_ready = 0;
  logic [31:0]    m_data;
  logic [2:0]     m_tile_row;
  logic [4:0]     m_tile_col;
  logic [2:0]     m_elem_idx;
  logic           m_last;
  logic           done;
  logic           overflow;
  logic [2:0]     fifo_level;
`ifdef RESULT_DRAIN_CHECKSUM_EN
  logic [31:0]    checksum;
`endif

  int checks = 0;
  int fails = 0;
  beat_t q[$];
  int max_level = 0;
  int run = 0;
  int last_run = 0;
  int done_cnt = 0;
  logic exp_done = 0;
  logic [31:0] exp_sum = 0;

  result_drain dut (
    .clk          (clk),
    .rst          (rst),
    .row_valid    (row_valid),
    .row_data     (row_data),
    .row_tile_row (row_tile_row),
    .row_tile_col (row_tile_col),
    .row_last     (row_last),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_tile_row   (m_tile_row),
    .m_tile_col   (m_tile_col),
    .m_elem_idx   (m_elem_idx),
    .m_last       (m_last),
    .done         (done),
`ifdef RESULT_DRAIN_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .overflow     (overflow),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; drives the row for exactly one edge.
  task automatic push_row(input int base, input int tr, input int tc,
                          input bit last, input bit acc);
    beat_t e;
    row_valid = 1;
    for (int k = 0; k < AW; k++) row_data[k*DW +: DW] = base + k;
    row_tile_row = 3'(tr);
    row_tile_col = 5'(tc);
    row_last = last;
    if (acc) begin
      for (int k = 0; k < AW; k++) begin
        e.d = 32'(base + k);
        e.tr = 3'(tr);
        e.tc = 5'(tc);
        e.idx = 3'(k);
        e.last = last && (k == AW - 1);
        q.push_back(e);
      end
    end
    @(posedge clk); #1;
    row_valid = 0;
    row_last = 0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || m_valid) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", 64'(q.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    q.delete();
    exp_sum = 0;
    exp_done = 0;
  endtask

  // Output monitor and scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (32'(fifo_level) > max_level) max_level = 32'(fifo_level);
      if (m_valid) run++;
      else if (run != 0) begin
        last_run = run;
        run = 0;
      end
      if (done) done_cnt++;
      if (exp_done || done) chk("done_pulse", done, exp_done);
`ifdef RESULT_DRAIN_CHECKSUM_EN
      if (done) chk("checksum", checksum, exp_sum);
`endif
      if (done) exp_sum = 0;
      exp_done = 0;
      if (m_valid) begin
        if (q.size() == 0) chk("unexpected_beat", m_valid, 0);
        else begin
          e = q[0];
          if (m_ready) begin
            chk("beat_data", m_data, e.d);
            chk("beat_tr", m_tile_row, e.tr);
            chk("beat_tc", m_tile_col, e.tc);
            chk("beat_idx", m_elem_idx, e.idx);
            chk("beat_last", m_last, e.last);
            void'(q.pop_front());
            exp_done = e.last;
            exp_sum = exp_sum + e.d;
          end else begin
            chk("hold_data", m_data, e.d);
            chk("hold_idx", m_elem_idx, e.idx);
            chk("hold_tags", {m_tile_row, m_tile_col}, {e.tr, e.tc});
            chk("hold_last", m_last, e.last);
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 0;

    // Single row, latency and tags.
    m_ready = 1;
    push_row(0, 2, 5, 0, 1);
    @(negedge clk);
    chk("lat_t1", m_valid, 0);
    @(negedge clk);
    chk("lat_t2", m_valid, 1);
    wait_drain();

    // Four back-to-back rows, no bubble.
    max_level = 0;
    push_row(16, 1, 3, 0, 1);
    push_row(32, 2, 4, 0, 1);
    push_row(48, 3, 6, 0, 1);
    push_row(64, 4, 7, 0, 1);
    wait_drain();
    chk("b2b_run", 64'(last_run), 32);
    chk("b2b_peak", 64'(max_level), 3);

    // Ready toggling stalls.
    m_ready = 0;
    push_row(80, 5, 9, 0, 1);
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      m_ready = ~m_ready;
    end
    m_ready = 1;
    wait_drain();

    // Fill to DEPTH, then overflow, then push-with-pop at full.
    m_ready = 0;
    push_row(100, 0, 1, 0, 1);
    push_row(200, 1, 2, 0, 1);
    push_row(300, 2, 3, 0, 1);
    push_row(400, 3, 4, 0, 1);
    push_row(500, 4, 5, 0, 1);
    @(negedge clk);
    chk("full_level", fifo_level, 4);
    chk("full_no_ovf", overflow, 0);
    @(posedge clk); #1;
    push_row(600, 5, 6, 0, 0);
    @(negedge clk);
    chk("ovf_set", overflow, 1);
    chk("ovf_level", fifo_level, 4);
    @(posedge clk); #1;
    m_ready = 1;
    for (int i = 0; i < 20; i++) begin
      if (m_valid && m_elem_idx == 3'd7) break;
      @(posedge clk); #1;
    end
    chk("pp_at_end", m_elem_idx, 7);
    push_row(700, 6, 7, 0, 1);
    chk("pp_level", fifo_level, 4);
    wait_drain();
    chk("ovf_sticky", overflow, 1);

    // Job end: m_last, done, checksum.
    do_reset();
    chk("rst_ovf_clr", overflow, 0);
    done_cnt = 0;
    push_row(0, 1, 1, 0, 1);
    push_row(8, 1, 2, 1, 1);
    wait_drain();
    chk("done_count", 64'(done_cnt), 1);

    // Reset mid-row.
    push_row(900, 2, 2, 0, 1);
    push_row(1000, 3, 3, 0, 1);
    for (int i = 0; i < 20; i++) begin
      if (m_valid && m_elem_idx == 3'd3) break;
      @(posedge clk); #1;
    end
    chk("mid_idx", m_elem_idx, 3);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    q.delete();
    exp_sum = 0;
    exp_done = 0;
    @(negedge clk);
    chk("mid_valid", m_valid, 0);
    chk("mid_level", fifo_level, 0);
    @(posedge clk); #1;
    push_row(1100, 7, 31, 1, 1);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
